// File: rtl/regfile_issue_scheduler_if.sv
// Issue / write-back bundle between the VLIW decoder, execution units and the dual-port regfile.
// master = decoder/execution/regfile side, slave = regfile_issue_scheduler.
interface regfile_issue_scheduler_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 3
);
    localparam int NREGS = 2 ** RADDR_W;

    logic               issue_valid;
    logic               issue_ready;
    logic [RADDR_W-1:0] mem_rn;
    logic [RADDR_W-1:0] mem_rd;
    logic               mem_load;
    logic [RADDR_W-1:0] alu_rn;
    logic [RADDR_W-1:0] alu_rm;
    logic [RADDR_W-1:0] alu_rd;
    logic               alu_wr;
    logic               mem_fire;
    logic               alu_fire;
    logic               alu_res_valid;
    logic [RADDR_W-1:0] alu_res_rd;
    logic [DATA_W-1:0]  alu_res_data;
    logic               ld_ret_valid;
    logic [RADDR_W-1:0] ld_ret_rd;
    logic [DATA_W-1:0]  ld_ret_data;
    logic               mem_regWrite;
    logic [RADDR_W-1:0] mem_wrd;
    logic [DATA_W-1:0]  mem_writeData;
    logic               alu_regWrite;
    logic [RADDR_W-1:0] alu_wrd;
    logic [DATA_W-1:0]  alu_writeData;
    logic               drain_req;
    logic               drain_done;
    logic [NREGS-1:0]   busy_bits;

    modport master (
        output issue_valid, mem_rn, mem_rd, mem_load, alu_rn, alu_rm, alu_rd, alu_wr,
        output alu_res_valid, alu_res_rd, alu_res_data, ld_ret_valid, ld_ret_rd, ld_ret_data,
        output drain_req,
        input  issue_ready, mem_fire, alu_fire, mem_regWrite, mem_wrd, mem_writeData,
        input  alu_regWrite, alu_wrd, alu_writeData, drain_done, busy_bits
    );

    modport slave (
        input  issue_valid, mem_rn, mem_rd, mem_load, alu_rn, alu_rm, alu_rd, alu_wr,
        input  alu_res_valid, alu_res_rd, alu_res_data, ld_ret_valid, ld_ret_rd, ld_ret_data,
        input  drain_req,
        output issue_ready, mem_fire, alu_fire, mem_regWrite, mem_wrd, mem_writeData,
        output alu_regWrite, alu_wrd, alu_writeData, drain_done, busy_bits
    );
endinterface

// File: rtl/regfile_issue_scheduler.sv
// Load scoreboard, RAW/WAW issue stall, same-rd bundle split and registered dual-port write-back.
// Optional macro REGSCHED_WB_BYPASS_EN: a returning load clears its hazard in the same cycle.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RUN   | normal issue, bundles accepted when hazard-free
// ST_SPLIT | mem half of a same-rd bundle sent, alu half waits for the load
// ST_DRAIN | issue frozen until drain_req drops; drain_done when no loads
module regfile_issue_scheduler #(
    parameter int DATA_W    = 32,
    parameter int RADDR_W   = 3,
    parameter int MAX_LOADS = 4
) (
    input logic                       clk,
    input logic                       reset,
    regfile_issue_scheduler_if.slave  bus
);
    localparam int NREGS = 2 ** RADDR_W;
    localparam logic [NREGS-1:0] ONE = {{(NREGS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {ST_RUN, ST_SPLIT, ST_DRAIN} state_t;

    state_t             r_state;
    logic [NREGS-1:0]   r_busy;
    logic [3:0]         r_count;
    logic [RADDR_W-1:0] r_split_rd;
    logic               r_mem_we;
    logic [RADDR_W-1:0] r_mem_wrd;
    logic [DATA_W-1:0]  r_mem_data;
    logic               r_alu_we;
    logic [RADDR_W-1:0] r_alu_wrd;
    logic [DATA_W-1:0]  r_alu_data;

    logic [NREGS-1:0]   w_ret_onehot;
    logic [NREGS-1:0]   w_set_onehot;
    logic [NREGS-1:0]   w_busy_chk;
    logic               w_full;
    logic               w_hazard;
    logic               w_fire;
    logic               w_fire_load;
    logic               w_split;
    logic               w_split_go;
    logic               w_alu_kill;

    assign w_ret_onehot = bus.ld_ret_valid ? (ONE << bus.ld_ret_rd) : '0;
    assign w_set_onehot = w_fire_load ? (ONE << bus.mem_rd) : '0;

`ifdef REGSCHED_WB_BYPASS_EN
    assign w_busy_chk = r_busy & ~w_ret_onehot;
`else
    assign w_busy_chk = r_busy;
`endif

    assign w_full   = (r_count == 4'(MAX_LOADS));
    assign w_hazard = w_busy_chk[bus.mem_rn] | w_busy_chk[bus.alu_rn] | w_busy_chk[bus.alu_rm]
                    | (bus.mem_load & w_busy_chk[bus.mem_rd])
                    | (bus.alu_wr & w_busy_chk[bus.alu_rd])
                    | (bus.mem_load & w_full);

    // reset gates the handshake so a mid-cycle reset kills issue immediately
    assign w_fire      = reset & (r_state == ST_RUN) & bus.issue_valid & ~w_hazard & ~bus.drain_req;
    assign w_fire_load = w_fire & bus.mem_load;
    assign w_split     = w_fire & bus.mem_load & bus.alu_wr & (bus.mem_rd == bus.alu_rd);
    // the split wait uses the registered scoreboard so the alu half lands after the load data
    assign w_split_go  = (r_state == ST_SPLIT) & ~r_busy[r_split_rd];
    assign w_alu_kill  = bus.ld_ret_valid & (bus.ld_ret_rd == bus.alu_res_rd);

    assign bus.issue_ready   = w_fire;
    assign bus.mem_fire      = w_fire;
    assign bus.alu_fire      = (w_fire & bus.alu_wr & ~w_split) | w_split_go;
    assign bus.drain_done    = (r_state == ST_DRAIN) & bus.drain_req & (r_count == 4'd0);
    assign bus.busy_bits     = r_busy;
    assign bus.mem_regWrite  = r_mem_we;
    assign bus.mem_wrd       = r_mem_wrd;
    assign bus.mem_writeData = r_mem_data;
    assign bus.alu_regWrite  = r_alu_we;
    assign bus.alu_wrd       = r_alu_wrd;
    assign bus.alu_writeData = r_alu_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_RUN;
            r_split_rd <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_split) begin
                        r_state    <= ST_SPLIT;
                        r_split_rd <= bus.alu_rd;
                    end else if (bus.drain_req && !w_fire) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_SPLIT: begin
                    if (w_split_go) r_state <= ST_RUN;
                end
                ST_DRAIN: begin
                    if (!bus.drain_req) r_state <= ST_RUN;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // set wins over clear when a load re-targets the register returning this edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            r_busy <= (r_busy & ~w_ret_onehot) | w_set_onehot;
            case ({w_fire_load, bus.ld_ret_valid})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   if (r_count != 4'd0) r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_we   <= 1'b0;
            r_mem_wrd  <= '0;
            r_mem_data <= '0;
            r_alu_we   <= 1'b0;
            r_alu_wrd  <= '0;
            r_alu_data <= '0;
        end else begin
            r_mem_we   <= bus.ld_ret_valid;
            r_mem_wrd  <= bus.ld_ret_rd;
            r_mem_data <= bus.ld_ret_data;
            r_alu_we   <= bus.alu_res_valid & ~w_alu_kill;
            r_alu_wrd  <= bus.alu_res_rd;
            r_alu_data <= bus.alu_res_data;
        end
    end
endmodule

// File: tb/tb_regfile_issue_scheduler.sv
// Self-checking bench for regfile_issue_scheduler: directed scenarios plus a randomized run
// against a set-of-pending-loads reference model. Honours REGSCHED_WB_BYPASS_EN when defined.
module tb_regfile_issue_scheduler;
    localparam int DATA_W    = 32;
    localparam int RADDR_W   = 3;
    localparam int NREGS     = 8;
    localparam int MAX_LOADS = 4;
`ifdef REGSCHED_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int RAW_CYC = BYP ? 5 : 6;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   pend [NREGS];

    always #5 clk = ~clk;

    regfile_issue_scheduler_if #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) bus ();

    regfile_issue_scheduler #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .MAX_LOADS(MAX_LOADS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0; bus.mem_rn = '0; bus.mem_rd = '0; bus.mem_load = 1'b0;
        bus.alu_rn = '0; bus.alu_rm = '0; bus.alu_rd = '0; bus.alu_wr = 1'b0;
        bus.alu_res_valid = 1'b0; bus.alu_res_rd = '0; bus.alu_res_data = '0;
        bus.ld_ret_valid = 1'b0; bus.ld_ret_rd = '0; bus.ld_ret_data = '0;
        bus.drain_req = 1'b0;
    endtask

    task automatic bundle(input logic ld, input logic [2:0] mrn, input logic [2:0] mrd,
                          input logic aw, input logic [2:0] arn, input logic [2:0] arm,
                          input logic [2:0] ard);
        bus.issue_valid = 1'b1; bus.mem_load = ld; bus.mem_rn = mrn; bus.mem_rd = mrd;
        bus.alu_wr = aw; bus.alu_rn = arn; bus.alu_rm = arm; bus.alu_rd = ard;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    function automatic bit mbusy(input logic [2:0] r);
        return pend[r] && !(BYP && bus.ld_ret_valid && bus.ld_ret_rd == r);
    endfunction

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.busy_bits !== 8'h00 || bus.issue_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: busy=%h ready=%b expected busy=00 ready=0", bus.busy_bits, bus.issue_ready);
        end
        bundle(1, 0, 2, 0, 0, 0, 0);
        tick();
        idle();
        bus.ld_ret_valid = 1'b1; bus.ld_ret_rd = 3'd7; bus.ld_ret_data = 32'hDEAD0007;
        bus.alu_res_valid = 1'b1; bus.alu_res_rd = 3'd6; bus.alu_res_data = 32'd9;
        tick();
        idle();
        bus.issue_valid = 1'b1;
        #1;
        n_checks++;
        if ({bus.issue_ready, bus.busy_bits, bus.mem_regWrite, bus.mem_wrd} !== {1'b1, 8'h04, 1'b1, 3'd7}) begin
            n_fail++; $display("FAIL reset_pre: ready=%b busy=%h mwe=%b mwrd=%0d expected 1 04 1 7",
                               bus.issue_ready, bus.busy_bits, bus.mem_regWrite, bus.mem_wrd);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.issue_ready, bus.mem_fire, bus.alu_fire, bus.mem_regWrite, bus.alu_regWrite, bus.drain_done} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctl: ready/mf/af/mwe/awe/done=%b%b%b%b%b%b expected 000000", bus.issue_ready,
                               bus.mem_fire, bus.alu_fire, bus.mem_regWrite, bus.alu_regWrite, bus.drain_done);
        end
        n_checks++;
        if ({bus.mem_wrd, bus.alu_wrd, bus.mem_writeData, bus.alu_writeData, bus.busy_bits} !== '0) begin
            n_fail++; $display("FAIL reset_data: mwrd=%0d awrd=%0d md=%h ad=%h busy=%h expected all 0",
                               bus.mem_wrd, bus.alu_wrd, bus.mem_writeData, bus.alu_writeData, bus.busy_bits);
        end
        tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.busy_bits !== 8'h00 || bus.issue_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release: busy=%h ready=%b expected busy=00 ready=1", bus.busy_bits, bus.issue_ready);
        end
        idle();
        tick();
    endtask

    task automatic test_raw();
        bit fired = 1'b0;
        do_reset();
        bundle(1, 0, 3, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (bus.issue_ready !== 1'b1) begin
            n_fail++; $display("FAIL raw_load_issue: ready=%b expected 1", bus.issue_ready);
        end
        tick();
        bundle(0, 0, 0, 1, 3, 0, 6);
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) begin
                n_checks++;
                if ({bus.mem_regWrite, bus.mem_wrd, bus.mem_writeData} !== {1'b1, 3'd3, 32'hC0DE0003}) begin
                    n_fail++; $display("FAIL raw_wb: mwe=%b mwrd=%0d md=%h expected 1 3 c0de0003",
                                       bus.mem_regWrite, bus.mem_wrd, bus.mem_writeData);
                end
            end
            if (fired) bus.issue_valid = 1'b0;
            bus.ld_ret_valid = (k == 5); bus.ld_ret_rd = 3'd3; bus.ld_ret_data = 32'hC0DE0003;
            #1;
            n_checks++;
            if (bus.issue_ready !== (!fired && k >= RAW_CYC)) begin
                n_fail++; $display("FAIL raw_ready T+%0d: ready=%b expected %b", k, bus.issue_ready, !fired && k >= RAW_CYC);
            end
            if (!fired && k >= RAW_CYC) begin
                n_checks++;
                if (bus.alu_fire !== 1'b1) begin
                    n_fail++; $display("FAIL raw_alu_fire T+%0d: alu_fire=%b expected 1", k, bus.alu_fire);
                end
                fired = 1'b1;
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_split();
        do_reset();
        bundle(1, 0, 5, 1, 1, 2, 5);
        #1;
        n_checks++;
        if ({bus.issue_ready, bus.mem_fire, bus.alu_fire} !== 3'b110) begin
            n_fail++; $display("FAIL split_issue: ready/mf/af=%b%b%b expected 110", bus.issue_ready, bus.mem_fire, bus.alu_fire);
        end
        tick();
        bundle(0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            bus.ld_ret_valid = (k == 4); bus.ld_ret_rd = 3'd5; bus.ld_ret_data = 32'h5555AAAA;
            #1;
            n_checks++;
            if (bus.alu_fire !== (k == 5) || bus.issue_ready !== 1'b0) begin
                n_fail++; $display("FAIL split_wait k=%0d: alu_fire=%b ready=%b expected %b 0", k, bus.alu_fire, bus.issue_ready, k == 5);
            end
            if (k == 1) begin
                n_checks++;
                if (bus.busy_bits !== 8'h20) begin
                    n_fail++; $display("FAIL split_busy: busy=%h expected 20", bus.busy_bits);
                end
            end
            if (k == 5) begin
                n_checks++;
                if ({bus.mem_regWrite, bus.mem_wrd, bus.alu_regWrite} !== {1'b1, 3'd5, 1'b0}) begin
                    n_fail++; $display("FAIL split_mem_wb: mwe=%b mwrd=%0d awe=%b expected 1 5 0", bus.mem_regWrite, bus.mem_wrd, bus.alu_regWrite);
                end
            end
            tick();
        end
        bus.ld_ret_valid = 1'b0;
        bus.alu_res_valid = 1'b1; bus.alu_res_rd = 3'd5; bus.alu_res_data = 32'h12345678;
        #1;
        n_checks++;
        if (bus.issue_ready !== 1'b1) begin
            n_fail++; $display("FAIL split_back_to_run: ready=%b expected 1", bus.issue_ready);
        end
        tick();
        idle();
        n_checks++;
        if ({bus.alu_regWrite, bus.alu_wrd, bus.alu_writeData, bus.mem_regWrite} !== {1'b1, 3'd5, 32'h12345678, 1'b0}) begin
            n_fail++; $display("FAIL split_alu_wb: awe=%b awrd=%0d ad=%h mwe=%b expected 1 5 12345678 0",
                               bus.alu_regWrite, bus.alu_wrd, bus.alu_writeData, bus.mem_regWrite);
        end
        tick();
    endtask

    task automatic test_capacity();
        do_reset();
        for (int r = 1; r <= 4; r++) begin
            bundle(1, 0, 3'(r), 0, 0, 0, 0);
            #1;
            n_checks++;
            if (bus.issue_ready !== 1'b1) begin
                n_fail++; $display("FAIL cap_load r%0d: ready=%b expected 1", r, bus.issue_ready);
            end
            tick();
        end
        bundle(1, 0, 6, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (bus.issue_ready !== 1'b0 || bus.busy_bits !== 8'h1E) begin
            n_fail++; $display("FAIL cap_full: ready=%b busy=%h expected 0 1e", bus.issue_ready, bus.busy_bits);
        end
        tick();
        bus.ld_ret_valid = 1'b1; bus.ld_ret_rd = 3'd1;
        #1;
        n_checks++;
        if (bus.issue_ready !== 1'b0) begin
            n_fail++; $display("FAIL cap_full_ret: ready=%b expected 0", bus.issue_ready);
        end
        tick();
        bus.ld_ret_rd = 3'd2;
        #1;
        n_checks++;
        if (bus.issue_ready !== 1'b1) begin
            n_fail++; $display("FAIL cap_swap: ready=%b expected 1", bus.issue_ready);
        end
        tick();
        bus.ld_ret_valid = 1'b0;
        bundle(1, 0, 7, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (bus.issue_ready !== 1'b1 || bus.busy_bits !== 8'h58) begin
            n_fail++; $display("FAIL cap_refill: ready=%b busy=%h expected 1 58", bus.issue_ready, bus.busy_bits);
        end
        tick();
        bundle(1, 0, 0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (bus.issue_ready !== 1'b0) begin
            n_fail++; $display("FAIL cap_full_again: ready=%b expected 0", bus.issue_ready);
        end
        idle();
        tick();
    endtask

    task automatic test_drain();
        do_reset();
        bundle(1, 0, 1, 0, 0, 0, 0);
        tick();
        bundle(1, 0, 2, 0, 0, 0, 0);
        tick();
        bundle(0, 0, 0, 0, 0, 0, 0);
        bus.drain_req = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            bus.ld_ret_valid = (k == 1 || k == 2);
            bus.ld_ret_rd    = (k == 1) ? 3'd1 : 3'd2;
            bus.drain_req    = (k <= 3);
            #1;
            n_checks++;
            if (bus.issue_ready !== (k == 5) || bus.drain_done !== (k == 3)) begin
                n_fail++; $display("FAIL drain k=%0d: ready=%b done=%b expected %b %b", k, bus.issue_ready, bus.drain_done, k == 5, k == 3);
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_writeback();
        do_reset();
        bus.ld_ret_valid = 1'b1; bus.ld_ret_rd = 3'd4; bus.ld_ret_data = 32'd256;
        bus.alu_res_valid = 1'b1; bus.alu_res_rd = 3'd1; bus.alu_res_data = 32'd4;
        tick();
        idle();
        n_checks++;
        if ({bus.mem_regWrite, bus.mem_wrd, bus.mem_writeData} !== {1'b1, 3'd4, 32'd256}) begin
            n_fail++; $display("FAIL wb_mem: mwe=%b mwrd=%0d md=%0d expected 1 4 256", bus.mem_regWrite, bus.mem_wrd, bus.mem_writeData);
        end
        n_checks++;
        if ({bus.alu_regWrite, bus.alu_wrd, bus.alu_writeData} !== {1'b1, 3'd1, 32'd4}) begin
            n_fail++; $display("FAIL wb_alu: awe=%b awrd=%0d ad=%0d expected 1 1 4", bus.alu_regWrite, bus.alu_wrd, bus.alu_writeData);
        end
        // a stray return must leave the load counter at zero, so four loads still fit
        for (int r = 1; r <= 5; r++) begin
            bundle(1, 0, 3'(r), 0, 0, 0, 0);
            #1;
            n_checks++;
            if (bus.issue_ready !== (r <= 4)) begin
                n_fail++; $display("FAIL wb_saturate r%0d: ready=%b expected %b", r, bus.issue_ready, r <= 4);
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        logic [2:0]  pick [$];
        logic        exp_ready, hz, p_ret, p_res;
        logic [2:0]  p_ret_rd, p_res_rd;
        logic [31:0] p_ret_d, p_res_d;
        logic [7:0]  mv;
        int          npend;
        do_reset();
        for (int i = 0; i < NREGS; i++) pend[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            bundle($urandom_range(0, 1), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   $urandom_range(0, 1), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)));
            bus.issue_valid = ($urandom_range(0, 3) != 0);
            if (bus.mem_load && bus.alu_wr && bus.mem_rd == bus.alu_rd) bus.alu_rd = bus.alu_rd + 3'd1;
            pick.delete();
            npend = 0;
            for (int r = 0; r < NREGS; r++) if (pend[r]) begin pick.push_back(3'(r)); npend++; end
            bus.ld_ret_valid = (npend > 0) && ($urandom_range(0, 2) == 0);
            bus.ld_ret_rd    = (npend > 0) ? pick[$urandom_range(0, npend - 1)] : 3'd0;
            bus.ld_ret_data  = $urandom;
            bus.alu_res_valid = $urandom_range(0, 1);
            bus.alu_res_rd    = 3'($urandom_range(0, 7));
            bus.alu_res_data  = $urandom;
            if (bus.ld_ret_valid && bus.alu_res_valid && bus.alu_res_rd == bus.ld_ret_rd) bus.alu_res_rd = bus.alu_res_rd + 3'd1;
            #1;
            hz = mbusy(bus.mem_rn) || mbusy(bus.alu_rn) || mbusy(bus.alu_rm)
               || (bus.mem_load && mbusy(bus.mem_rd)) || (bus.alu_wr && mbusy(bus.alu_rd))
               || (bus.mem_load && npend == MAX_LOADS);
            exp_ready = bus.issue_valid && !hz;
            n_checks++;
            if ({bus.issue_ready, bus.mem_fire, bus.alu_fire} !== {exp_ready, exp_ready, exp_ready && bus.alu_wr}) begin
                n_fail++; $display("FAIL rand_issue c=%0d: ready/mf/af=%b%b%b expected %b%b%b", c, bus.issue_ready, bus.mem_fire,
                                   bus.alu_fire, exp_ready, exp_ready, exp_ready && bus.alu_wr);
            end
            p_ret = bus.ld_ret_valid; p_ret_rd = bus.ld_ret_rd; p_ret_d = bus.ld_ret_data;
            p_res = bus.alu_res_valid; p_res_rd = bus.alu_res_rd; p_res_d = bus.alu_res_data;
            if (p_ret) pend[p_ret_rd] = 1'b0;
            if (exp_ready && bus.mem_load) pend[bus.mem_rd] = 1'b1;
            tick();
            for (int r = 0; r < NREGS; r++) mv[r] = pend[r];
            n_checks++;
            if (bus.busy_bits !== mv) begin
                n_fail++; $display("FAIL rand_busy c=%0d: busy=%h expected %h", c, bus.busy_bits, mv);
            end
            n_checks++;
            if (bus.mem_regWrite !== p_ret || (p_ret && {bus.mem_wrd, bus.mem_writeData} !== {p_ret_rd, p_ret_d})) begin
                n_fail++; $display("FAIL rand_mem_wb c=%0d: mwe=%b mwrd=%0d md=%h expected %b %0d %h", c, bus.mem_regWrite,
                                   bus.mem_wrd, bus.mem_writeData, p_ret, p_ret_rd, p_ret_d);
            end
            n_checks++;
            if (bus.alu_regWrite !== p_res || (p_res && {bus.alu_wrd, bus.alu_writeData} !== {p_res_rd, p_res_d})) begin
                n_fail++; $display("FAIL rand_alu_wb c=%0d: awe=%b awrd=%0d ad=%h expected %b %0d %h", c, bus.alu_regWrite,
                                   bus.alu_wrd, bus.alu_writeData, p_res, p_res_rd, p_res_d);
            end
            n_checks++;
            if (bus.mem_regWrite && bus.alu_regWrite && bus.mem_wrd == bus.alu_wrd) begin
                n_fail++; $display("FAIL rand_port_collision c=%0d: both ports write r%0d, expected no collision", c, bus.mem_wrd);
            end
        end
        idle();
        tick();
    endtask

    initial begin
        idle();
        test_reset();
        test_raw();
        test_split();
        test_capacity();
        test_drain();
        test_writeback();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end
endmodule
